// File: rtl/sample_reader.sv
// sample_reader: reads one frame of samples from the sample FIFO and streams
// them as bytes over a valid/ready link. A header byte goes first.
// Optional feature macro: SAMPLE_READER_CHECKSUM_EN appends a running-XOR
// checksum byte after the last sample of each frame.
module sample_reader #(
   parameter int         DATA_SIZE = 8,
   parameter int         FRAME_LEN = 256,
   parameter logic [7:0] HEADER    = 8'hA5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [DATA_SIZE-1:0] fifo_data_i,
   input  logic                 fifo_empty_i,
   output logic                 r_en_o,
   output logic [7:0]           tx_data_o,
   output logic                 tx_valid_o,
   input  logic                 tx_ready_i,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST_C = CW'(FRAME_LEN);

`ifdef SAMPLE_READER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_HDR, S_RD, S_LAT, S_TX, S_CK, S_FIN} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_HDR, S_RD, S_LAT, S_TX, S_FIN} state_t;
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      data_q,  data_d;
   logic [7:0]      sample_ext;
`ifdef SAMPLE_READER_CHECKSUM_EN
   logic [7:0]      csum_q,  csum_d;
`endif

   // FIFO data zero-extended to a full byte
   assign sample_ext = 8'(fifo_data_i);

   // State, sample counter and held byte registers; reset leaves the FIFO alone
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         count_q <= '0;
         data_q  <= 8'h00;
`ifdef SAMPLE_READER_CHECKSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         data_q  <= data_d;
`ifdef SAMPLE_READER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   // Next-state logic and outputs; the byte on tx_data_o is held until accepted
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      data_d     = data_q;
`ifdef SAMPLE_READER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      r_en_o     = 1'b0;
      tx_valid_o = 1'b0;
      tx_data_o  = 8'h00;
      busy_o     = (state_q != S_IDLE);
      done_o     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_HDR;
               count_d = '0;
`ifdef SAMPLE_READER_CHECKSUM_EN
               csum_d  = 8'h00;
`endif
            end
         end
         S_HDR: begin
            tx_valid_o = 1'b1;
            tx_data_o  = HEADER;
            count_d    = '0;
`ifdef SAMPLE_READER_CHECKSUM_EN
            csum_d     = 8'h00;
`endif
            if (tx_ready_i) begin
               state_d = S_RD;
            end
         end
         S_RD: begin
            // Never read an empty FIFO; stall here until data shows up
            if (!fifo_empty_i) begin
               r_en_o  = 1'b1;
               state_d = S_LAT;
            end
         end
         S_LAT: begin
            // FIFO read data arrives one cycle after the read enable
            data_d  = sample_ext;
            count_d = count_q + 1'b1;
`ifdef SAMPLE_READER_CHECKSUM_EN
            csum_d  = csum_q ^ sample_ext;
`endif
            state_d = S_TX;
         end
         S_TX: begin
            tx_valid_o = 1'b1;
            tx_data_o  = data_q;
            if (tx_ready_i) begin
               if (count_q == LAST_C) begin
`ifdef SAMPLE_READER_CHECKSUM_EN
                  state_d = S_CK;
`else
                  state_d = S_FIN;
`endif
               end else begin
                  state_d = S_RD;
               end
            end
         end
`ifdef SAMPLE_READER_CHECKSUM_EN
         S_CK: begin
            tx_valid_o = 1'b1;
            tx_data_o  = csum_q;
            if (tx_ready_i) begin
               state_d = S_FIN;
            end
         end
`endif
         S_FIN: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
